// File: rtl/priority_decoder_3to8_seq.sv
// Queued 3-to-8 decoder: codes enter a 4-deep FIFO and each decoded one-hot
// word is held for HOLD_CYCLES cycles, then followed by one all-zero cycle.
module priority_decoder_3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] codeIn,
  input  logic       codeValid,
  output logic       codeReady,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic [2:0] fifoCount
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam logic [2:0]  FULL_CNT  = 3'(DEPTH);
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;
  logic [7:0]       holdCnt_q, holdCnt_d;
  logic [7:0]       dataOut_q, dataOut_d;
  logic             dataValid_q, dataValid_d;
  logic             push, pop;
  logic [2:0]       head;

  // Ready depends only on stored occupancy (and reset), never on codeValid.
  assign codeReady = ~reset & (count_q < FULL_CNT);
  assign push      = codeValid & codeReady;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      holdCnt_q   <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      holdCnt_q   <= holdCnt_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      if (push) begin
        mem_q[wr_ptr_q] <= codeIn;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Next-state logic; IDLE and GAP both start a new word when one is queued.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: if (holdCnt_q == 8'd0) state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / hold-counter logic
  always_comb begin
    dataOut_d   = dataOut_q;
    dataValid_d = dataValid_q;
    holdCnt_d   = holdCnt_q;
    if (pop) begin
      dataOut_d   = 8'd1 << head;
      dataValid_d = 1'b1;
      holdCnt_d   = HOLD_LOAD;
    end else if (state_q == S_HOLD) begin
      if (holdCnt_q != 8'd0) begin
        holdCnt_d = holdCnt_q - 8'd1;
      end else begin
        dataOut_d   = '0;
        dataValid_d = 1'b0;
      end
    end else begin
      dataOut_d   = '0;
      dataValid_d = 1'b0;
      holdCnt_d   = '0;
    end
  end

  assign dataOut   = dataOut_q;
  assign dataValid = dataValid_q;
  assign fifoCount = count_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    dataValid |-> $onehot(dataOut));
  a_zero:   assert property (@(posedge clk) disable iff (reset)
    !dataValid |-> (dataOut == 8'd0));
  a_count:  assert property (@(posedge clk) disable iff (reset)
    fifoCount <= FULL_CNT);
`endif

endmodule

// File: tb/tb_priority_decoder_3to8_seq.sv
// Scoreboard bench: two decoders (HOLD_CYCLES 4 and 1) share clock and reset.
module tb_priority_decoder_3to8_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0][2:0] code_in = '0;
  logic [1:0]      cv = '0;
  wire  [1:0]      cr, dv;
  wire  [1:0][7:0] dout;
  wire  [1:0][2:0] fcnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  priority_decoder_3to8_seq #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .codeIn(code_in[0]), .codeValid(cv[0]),
    .codeReady(cr[0]), .dataOut(dout[0]), .dataValid(dv[0]), .fifoCount(fcnt[0]));

  priority_decoder_3to8_seq #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .codeIn(code_in[1]), .codeValid(cv[1]),
    .codeReady(cr[1]), .dataOut(dout[1]), .dataValid(dv[1]), .fifoCount(fcnt[1]));

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Per-DUT scoreboard: accepted codes push the expected one-hot word;
  // each new dataValid run pops and compares.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int HC = (g == 0) ? 4 : 1;
    logic [7:0] q[$];
    int   pushes = 0, started = 0, run_len = 0, zero_len = 0;
    logic prev = 1'b0, backlog = 1'b0, rst_edge = 1'b1;
    logic [7:0] cur = '0;

    always @(posedge clk) begin
      rst_edge = reset;
      if (reset) begin
        q.delete();
        pushes  = 0;
        started = 0;
      end else if (cv[g] && cr[g]) begin
        q.push_back(8'd1 << code_in[g]);
        pushes++;
      end
    end

    always @(negedge clk) begin
      if (rst_edge) begin
        chk("rst_dv", dv[g], 0);
        chk("rst_dout", dout[g], 0);
        chk("rst_cnt", fcnt[g], 0);
        if (reset) chk("rst_rdy", cr[g], 0);
        prev = 1'b0; backlog = 1'b0; run_len = 0; zero_len = 0;
      end else begin
        if (dv[g] && !prev) begin
          if (q.size() == 0) chk("unexpected_word", dout[g], 0);
          else chk("word", dout[g], q.pop_front());
          started++;
          if (backlog) chk("gap_len", zero_len, 1);
          run_len = 1;
          cur = dout[g];
        end else if (dv[g]) begin
          chk("stable", dout[g], cur);
          run_len++;
        end else begin
          chk("zero_out", dout[g], 0);
          if (prev) begin
            chk("hold_len", run_len, HC);
            backlog  = (fcnt[g] != 0);
            zero_len = 1;
          end else begin
            zero_len++;
          end
        end
        chk("cnt", fcnt[g], pushes - started);
        chk("rdy", cr[g], (!reset && (pushes - started) < 4) ? 1 : 0);
        prev = dv[g];
      end
    end
  end

  task automatic send(input int d, input int c);
    bit ok = 0;
    @(posedge clk); #1;
    code_in[d] = 3'(c); cv[d] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (cr[d]) ok = 1;
    end
    #1 cv[d] = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic burst(input int d, input int n, input int start, output bit saw_full);
    int k = 0;
    saw_full = 0;
    @(posedge clk); #1;
    code_in[d] = 3'(start); cv[d] = 1'b1;
    for (int guard = 0; guard < 300 && k < n; guard++) begin
      @(posedge clk);
      if (cr[d]) k++;
      else saw_full = 1;
      #1 if (k < n) code_in[d] = 3'(start + k);
    end
    cv[d] = 1'b0;
    if (k != n) chk("burst_timeout", k, n);
  endtask

  task automatic drain(input int d);
    int idle = 0;
    for (int i = 0; i < 400 && idle < 2; i++) begin
      @(negedge clk);
      if (!dv[d] && fcnt[d] == 0) idle++;
      else idle = 0;
    end
    if (idle < 2) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit full;
    bit was;
    bit fell;
    // Reset: two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", cr[0], 1);

    // Single code 5
    send(0, 5);
    @(negedge clk);
    chk("single_k", dv[0], 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("single_word", dout[0], 8'h20);
    end
    @(negedge clk);
    chk("single_gap", dout[0], 0);
    @(negedge clk);
    chk("single_idle", dv[0], 0);
    chk("single_idle_cnt", fcnt[0], 0);
    drain(0);

    // Burst of codes 0..7
    burst(0, 8, 0, full);
    chk("burst_full_seen", full, 1);
    drain(0);

    // Push landing on the same edge as a pop with 3 queued
    burst(0, 4, 3, full);
    was = 1'b1; fell = 1'b0;
    for (int i = 0; i < 50 && !fell; i++) begin
      @(negedge clk);
      if (!dv[0] && was) fell = 1'b1;
      was = dv[0];
    end
    if (!fell) chk("fullpop_timeout", 0, 1);
    chk("fullpop_pre", fcnt[0], 3);
    code_in[0] = 3'd1; cv[0] = 1'b1;
    @(posedge clk); #1 cv[0] = 1'b0;
    @(negedge clk);
    chk("fullpop_cnt", fcnt[0], 3);
    drain(0);

    // HOLD_CYCLES=1 instance: 3 codes back to back
    burst(1, 3, 2, full);
    drain(1);

    // Reset in the second HOLD cycle with 2 codes queued
    burst(0, 3, 4, full);
    reset = 1'b1;
    cv[0] = 1'b1; code_in[0] = 3'd7;
    @(negedge clk);
    chk("midrst_hold", dv[0], 1);
    chk("midrst_q", fcnt[0], 2);
    @(posedge clk); #1;
    reset = 1'b0; cv[0] = 1'b0;
    @(negedge clk);
    chk("midrst_dout", dout[0], 0);
    chk("midrst_cnt", fcnt[0], 0);
    repeat (8) @(negedge clk);
    chk("midrst_quiet", dv[0], 0);
    send(0, 6);
    drain(0);

    chk("left0", mon[0].q.size(), 0);
    chk("left1", mon[1].q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/priority_decoder_3to8_seq.md
PRIORITY_DECODER_3TO8_SEQ -- requirements
Module: priority_decoder_3to8_seq

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 4, legal range 1..255: number of cycles each decoded one-hot word is driven.
REQ-002 The module SHALL have parameter DEPTH, fixed at 4: capacity of the input code queue in entries.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port codeIn  input  3  binary code to decode (0..7).
REQ-006 The module SHALL have port codeValid  input  1  codeIn is offered this cycle.
REQ-007 The module SHALL have port codeReady  output  1  queue can accept a code this cycle.
REQ-008 The module SHALL have port dataOut  output  8  registered one-hot decode of the current code, else all zero.
REQ-009 The module SHALL have port dataValid  output  1  dataOut holds a decoded word.
REQ-010 The module SHALL have port fifoCount  output  3  number of queued codes, 0..4.

Function
REQ-011 A code SHALL be accepted at a rising edge only when codeValid=1 and codeReady=1; accepted codes SHALL be queued in FIFO order, with none dropped or duplicated.
REQ-012 codeReady SHALL equal (fifoCount < 4), driven from registered state only, with no combinational path from codeValid.
REQ-013 A push and a pop at the same edge SHALL leave fifoCount unchanged; the queue read and write pointers SHALL wrap modulo 4.
REQ-014 The output FSM SHALL have the states IDLE, HOLD and GAP.
REQ-015 In IDLE with fifoCount>0, the FSM SHALL pop the head code at the next edge, register dataOut = 8'b1 << code, set dataValid=1, load holdCnt = HOLD_CYCLES-1, and enter HOLD.
REQ-016 In IDLE with fifoCount=0, the FSM SHALL remain in IDLE with dataOut=0 and dataValid=0.
REQ-017 In HOLD, the FSM SHALL keep dataOut stable; with holdCnt>0 it SHALL decrement holdCnt, and with holdCnt=0 it SHALL clear dataOut and dataValid at the next edge and enter GAP.
REQ-018 GAP SHALL last exactly one cycle with dataOut=0; from GAP the FSM SHALL pop and enter HOLD as in IDLE if fifoCount>0, else enter IDLE.
REQ-019 Latency: a code accepted at edge k into an empty queue with the FSM in IDLE SHALL appear on dataOut after edge k+1 and be driven for exactly HOLD_CYCLES cycles, followed by one zero cycle.
REQ-020 With a continuously non-empty queue, decoded words SHALL repeat with period HOLD_CYCLES+1 cycles.
REQ-021 The queue SHALL be pushable while full-with-pop only when codeReady was already 1 in that cycle (REQ-012 governs; no full-bypass).
REQ-022 dataOut SHALL have exactly one bit set whenever dataValid=1, and SHALL be all zero whenever dataValid=0.

Reset
REQ-023 While reset=1 at an edge: the queue SHALL be emptied (fifoCount=0), the FSM SHALL enter IDLE, holdCnt SHALL be 0, dataOut SHALL be 8'b00000000, and dataValid SHALL be 0.
REQ-024 codeReady SHALL be 0 in any cycle where reset=1, and 1 in the first cycle after reset is released.
REQ-025 Reset asserted mid-HOLD SHALL zero dataOut after that edge and discard all queued codes; reset SHALL take priority over a simultaneous push.

Verification (HOLD_CYCLES=4 unless stated)
REQ-026 Reset scenario: reset=1 for 2 cycles -> dataOut=00000000, dataValid=0, fifoCount=0, codeReady=0 during reset and 1 afterwards.
REQ-027 Single-code scenario: codeIn=3'b101 accepted at edge k -> dataOut=00100000 after edges k+1..k+4, 00000000 after edge k+5, FSM in IDLE after edge k+6.
REQ-028 Burst scenario: codes 0..7 offered with codeValid held high -> codeReady drops when fifoCount=4, all 8 codes are output in order 00000001, 00000010, ..., 10000000, each for 4 cycles separated by one zero cycle, with no loss.
REQ-029 Full-plus-pop scenario: queue at 3 entries, push coinciding with an FSM pop -> fifoCount stays 3 and order is preserved.
REQ-030 Mid-operation reset scenario: reset asserted during the second HOLD cycle with 2 codes queued -> dataOut=0 next cycle, fifoCount=0, and no queued code is ever output.
REQ-031 HOLD_CYCLES=1 scenario: 3 codes queued -> dataOut alternates one-hot, zero, one-hot, zero, one-hot, zero.
